occ_gtp_link_sequencer: RTL and testbench

Reset and bring-up sequencer for one OCC GTPE2 tile, running in the init clock domain. Drives the tile's PLL, TX and RX resets, user-ready strobes and comma-align enable in the required order, with per-step timeouts and bounded retries. Reports link state to the OCC core. Sits between the system reset logic and `occ_gtpe2_tile`.

---
 rtl/occ_gtp_pkg.sv | 34 +++
 rtl/occ_gtp_sync2.sv | 15 +
 rtl/occ_gtp_link_sequencer.sv | 172 +++++++++++++++++
 tb/tb_occ_gtp_link_sequencer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/occ_gtp_pkg.sv
// rtl/occ_gtp_pkg.sv - state encoding and default timing constants for the GTP link sequencer
package occ_gtp_pkg;

   typedef enum logic [3:0] {
      ST_PLL_RST     = 4'd0,
      ST_WAIT_LOCK   = 4'd1,
      ST_TX_RST      = 4'd2,
      ST_WAIT_TXDONE = 4'd3,
      ST_RX_RST      = 4'd4,
      ST_WAIT_RXDONE = 4'd5,
      ST_ALIGN       = 4'd6,
      ST_LINK_UP     = 4'd7,
      ST_FAULT       = 4'd8
   } gtp_state_t;

   localparam int C_PLL_RST_CYCLES   = 200;
   localparam int C_RST_PULSE_CYCLES = 4;
   localparam int C_TIMEOUT_CYCLES   = 65535;
   localparam int C_ALIGN_CYCLES     = 1024;
   localparam int C_MAX_RETRIES      = 7;
   localparam int C_ERR_THRESHOLD    = 16;
   localparam int C_ERR_WINDOW       = 4096;

   // Bits needed to count up to (largest - 1); the timer compares against count-1.
   function automatic int timer_width(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return (m > 1) ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/occ_gtp_sync2.sv
// rtl/occ_gtp_sync2.sv - two-flop level synchroniser into the init clock domain
module occ_gtp_sync2 (
   input  logic clk,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      meta <= d;
      q    <= meta;
   end

endmodule

// File: rtl/occ_gtp_link_sequencer.sv
// rtl/occ_gtp_link_sequencer.sv - GTPE2 tile reset/bring-up sequencer with timeouts and bounded retries
// The rx error-rate relink monitor is built only when OCC_GTP_LINK_MONITOR_EN is defined.
module occ_gtp_link_sequencer
   import occ_gtp_pkg::*;
#(
   parameter int g_PLL_RST_CYCLES   = C_PLL_RST_CYCLES,
   parameter int g_RST_PULSE_CYCLES = C_RST_PULSE_CYCLES,
   parameter int g_TIMEOUT_CYCLES   = C_TIMEOUT_CYCLES,
   parameter int g_ALIGN_CYCLES     = C_ALIGN_CYCLES,
   parameter int g_MAX_RETRIES      = C_MAX_RETRIES,
   parameter int g_ERR_THRESHOLD    = C_ERR_THRESHOLD,
   parameter int g_ERR_WINDOW       = C_ERR_WINDOW
) (
   input  logic       init_clk_i,
   input  logic       init_rst_i,
   input  logic       restart_i,
   input  logic       pll_lock_i,
   input  logic       txresetdone_i,
   input  logic       rxresetdone_i,
   input  logic       rx_err_i,
   output logic       pll_rst_o,
   output logic       txreset_o,
   output logic       rxreset_o,
   output logic       txuserrdy_o,
   output logic       rxuserrdy_o,
   output logic       rxencommaalign_o,
   output logic       link_up_o,
   output logic       fault_o,
   output logic [3:0] state_o,
   output logic [2:0] retry_cnt_o
);

   localparam int TW = timer_width(g_PLL_RST_CYCLES, g_RST_PULSE_CYCLES,
                                   g_TIMEOUT_CYCLES, g_ALIGN_CYCLES);

   logic pll_lock;
   logic txresetdone;
   logic rxresetdone;

   occ_gtp_sync2 u_sync_lock   (.clk(init_clk_i), .d(pll_lock_i),    .q(pll_lock));
   occ_gtp_sync2 u_sync_txdone (.clk(init_clk_i), .d(txresetdone_i), .q(txresetdone));
   occ_gtp_sync2 u_sync_rxdone (.clk(init_clk_i), .d(rxresetdone_i), .q(rxresetdone));

   gtp_state_t    state;
   gtp_state_t    nxt;
   logic [TW-1:0] timer;
   logic [2:0]    retry_cnt;
   logic          bump_retry;
   logic          retry_last;
   logic          lock_lost;
   logic          timed_out;
   logic          monitor_trip;

   assign state_o     = state;
   assign retry_cnt_o = retry_cnt;

   assign retry_last = (int'(retry_cnt) >= g_MAX_RETRIES - 1);
   assign timed_out  = (timer == TW'(g_TIMEOUT_CYCLES - 1));
   assign lock_lost  = !pll_lock &&
                       (state inside {ST_TX_RST, ST_WAIT_TXDONE, ST_RX_RST,
                                      ST_WAIT_RXDONE, ST_ALIGN, ST_LINK_UP});

`ifdef OCC_GTP_LINK_MONITOR_EN
   localparam int EW = $clog2(g_ERR_THRESHOLD + 1);
   localparam int WW = (g_ERR_WINDOW > 1) ? $clog2(g_ERR_WINDOW) : 1;

   logic [EW-1:0] err_cnt;
   logic [WW-1:0] win_cnt;

   assign monitor_trip = (state == ST_LINK_UP) && rx_err_i &&
                         (err_cnt == EW'(g_ERR_THRESHOLD - 1));

   // Window and count restart together; both are held at zero outside LINK_UP.
   always_ff @(posedge init_clk_i) begin
      if (init_rst_i || state != ST_LINK_UP || win_cnt == WW'(g_ERR_WINDOW - 1)) begin
         win_cnt <= '0;
         err_cnt <= '0;
      end else begin
         win_cnt <= win_cnt + 1'b1;
         if (rx_err_i && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
      end
   end
`else
   localparam int unused_err_cfg = g_ERR_THRESHOLD + g_ERR_WINDOW;
   logic unused_rx_err;

   assign unused_rx_err = rx_err_i;
   assign monitor_trip  = 1'b0;
`endif

   always_comb begin
      nxt        = state;
      bump_retry = 1'b0;
      if (restart_i || lock_lost) begin
         nxt = ST_PLL_RST;
      end else begin
         unique case (state)
            ST_PLL_RST:
               if (timer == TW'(g_PLL_RST_CYCLES - 1)) nxt = ST_WAIT_LOCK;
            ST_WAIT_LOCK:
               if (pll_lock) nxt = ST_TX_RST;
               else if (timed_out) begin
                  bump_retry = 1'b1;
                  nxt        = retry_last ? ST_FAULT : ST_PLL_RST;
               end
            ST_TX_RST:
               if (timer == TW'(g_RST_PULSE_CYCLES - 1)) nxt = ST_WAIT_TXDONE;
            ST_WAIT_TXDONE:
               if (txresetdone) nxt = ST_RX_RST;
               else if (timed_out) begin
                  bump_retry = 1'b1;
                  nxt        = retry_last ? ST_FAULT : ST_PLL_RST;
               end
            ST_RX_RST:
               if (timer == TW'(g_RST_PULSE_CYCLES - 1)) nxt = ST_WAIT_RXDONE;
            ST_WAIT_RXDONE:
               if (rxresetdone) nxt = ST_ALIGN;
               else if (timed_out) begin
                  bump_retry = 1'b1;
                  nxt        = retry_last ? ST_FAULT : ST_PLL_RST;
               end
            ST_ALIGN:
               if (!rxresetdone) nxt = ST_RX_RST;
               else if (timer == TW'(g_ALIGN_CYCLES - 1)) nxt = ST_LINK_UP;
            ST_LINK_UP:
               if (!rxresetdone) nxt = ST_RX_RST;
               else if (monitor_trip) begin
                  bump_retry = 1'b1;
                  nxt        = retry_last ? ST_FAULT : ST_RX_RST;
               end
            ST_FAULT:
               nxt = ST_FAULT;
            default:
               nxt = ST_PLL_RST;
         endcase
      end
   end

   // Outputs are decoded from the next state so they register together with it.
   always_ff @(posedge init_clk_i) begin
      if (init_rst_i) begin
         state            <= ST_PLL_RST;
         timer            <= '0;
         retry_cnt        <= '0;
         pll_rst_o        <= 1'b1;
         txreset_o        <= 1'b1;
         rxreset_o        <= 1'b1;
         txuserrdy_o      <= 1'b0;
         rxuserrdy_o      <= 1'b0;
         rxencommaalign_o <= 1'b0;
         link_up_o        <= 1'b0;
         fault_o          <= 1'b0;
      end else begin
         state <= nxt;
         if (nxt != state || restart_i) timer <= '0;
         else if (timer != '1)          timer <= timer + 1'b1;
         if (restart_i)                               retry_cnt <= '0;
         else if (bump_retry && retry_cnt != 3'b111) retry_cnt <= retry_cnt + 1'b1;
         pll_rst_o        <= (nxt inside {ST_PLL_RST, ST_FAULT});
         txreset_o        <= (nxt inside {ST_PLL_RST, ST_WAIT_LOCK, ST_TX_RST, ST_FAULT});
         rxreset_o        <= (nxt inside {ST_PLL_RST, ST_WAIT_LOCK, ST_TX_RST,
                                          ST_WAIT_TXDONE, ST_RX_RST, ST_FAULT});
         txuserrdy_o      <= (nxt inside {ST_WAIT_TXDONE, ST_RX_RST, ST_WAIT_RXDONE,
                                          ST_ALIGN, ST_LINK_UP});
         rxuserrdy_o      <= (nxt inside {ST_WAIT_RXDONE, ST_ALIGN, ST_LINK_UP});
         rxencommaalign_o <= (nxt inside {ST_ALIGN, ST_LINK_UP});
         link_up_o        <= (nxt == ST_LINK_UP);
         fault_o          <= (nxt == ST_FAULT);
      end
   end

endmodule

// File: tb/tb_occ_gtp_link_sequencer.sv
// tb/tb_occ_gtp_link_sequencer.sv - directed bench for the GTP link sequencer (timeout shortened to 600)
module tb_occ_gtp_link_sequencer;

   logic       clk;
   logic       init_rst;
   logic       restart;
   logic       pll_lock;
   logic       txdone;
   logic       rxdone;
   logic       rx_err;
   logic       pll_rst;
   logic       txreset;
   logic       rxreset;
   logic       txuserrdy;
   logic       rxuserrdy;
   logic       comma;
   logic       link_up;
   logic       fault;
   logic [3:0] state;
   logic [2:0] retry;

   int   cyc;
   int   checks;
   int   errors;
   logic saw_pll_tx;

   occ_gtp_link_sequencer #(
      .g_PLL_RST_CYCLES  (200),
      .g_RST_PULSE_CYCLES(4),
      .g_TIMEOUT_CYCLES  (600),
      .g_ALIGN_CYCLES    (1024),
      .g_MAX_RETRIES     (7),
      .g_ERR_THRESHOLD   (16),
      .g_ERR_WINDOW      (4096)
   ) dut (
      .init_clk_i      (clk),
      .init_rst_i      (init_rst),
      .restart_i       (restart),
      .pll_lock_i      (pll_lock),
      .txresetdone_i   (txdone),
      .rxresetdone_i   (rxdone),
      .rx_err_i        (rx_err),
      .pll_rst_o       (pll_rst),
      .txreset_o       (txreset),
      .rxreset_o       (rxreset),
      .txuserrdy_o     (txuserrdy),
      .rxuserrdy_o     (rxuserrdy),
      .rxencommaalign_o(comma),
      .link_up_o       (link_up),
      .fault_o         (fault),
      .state_o         (state),
      .retry_cnt_o     (retry)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] outs();
      return {pll_rst, txreset, rxreset, txuserrdy, rxuserrdy, comma, link_up, fault};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (pll_rst || txreset) saw_pll_tx = 1'b1;
   endtask

   task automatic run_to(input int n);
      while (cyc < n) tick();
   endtask

   task automatic hold_reset();
      init_rst = 1'b1;
      tick();
      tick();
      tick();
   endtask

   task automatic release_reset();
      init_rst = 1'b0;
      cyc      = 0;
   endtask

   // s: cycle PLL_RST was entered; lock_cyc: cycle after which pll_lock_i is raised.
   task automatic bring_up(input int s, input int lock_cyc);
      int t;
      if (lock_cyc < s + 199) begin run_to(lock_cyc); pll_lock = 1'b1; end
      run_to(s + 199);
      checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL pll_rst_hold: got %b exp 1 at %0d", pll_rst, cyc); end
      run_to(s + 200);
      checks++; if (pll_rst !== 1'b0 || state !== 4'd1) begin errors++; $display("FAIL pll_rst_fall: got pll=%b st=%0d exp 0/1", pll_rst, state); end
      if (lock_cyc >= s + 199) begin run_to(lock_cyc); pll_lock = 1'b1; end
      t = (lock_cyc + 3 > s + 201) ? lock_cyc + 3 : s + 201;
      run_to(t + 3);
      checks++; if (txreset !== 1'b1 || state !== 4'd2) begin errors++; $display("FAIL tx_rst: got tx=%b st=%0d exp 1/2", txreset, state); end
      run_to(t + 4);
      checks++; if (outs() !== 8'b0011_0000 || state !== 4'd3) begin errors++; $display("FAIL wait_txdone: got %b st=%0d exp 00110000/3", outs(), state); end
      run_to(t + 24);
      txdone = 1'b1;
      run_to(t + 30);
      checks++; if (rxreset !== 1'b1 || state !== 4'd4) begin errors++; $display("FAIL rx_rst: got rx=%b st=%0d exp 1/4", rxreset, state); end
      run_to(t + 31);
      checks++; if (outs() !== 8'b0001_1000 || state !== 4'd5) begin errors++; $display("FAIL wait_rxdone: got %b st=%0d exp 00011000/5", outs(), state); end
      run_to(t + 51);
      rxdone = 1'b1;
      run_to(t + 53);
      checks++; if (comma !== 1'b0) begin errors++; $display("FAIL comma_early: got %b exp 0", comma); end
      run_to(t + 54);
      checks++; if (comma !== 1'b1 || state !== 4'd6) begin errors++; $display("FAIL align_entry: got comma=%b st=%0d exp 1/6", comma, state); end
      run_to(t + 1077);
      checks++; if (link_up !== 1'b0) begin errors++; $display("FAIL link_early: got %b exp 0", link_up); end
      run_to(t + 1078);
      checks++; if (outs() !== 8'b0001_1110 || state !== 4'd7) begin errors++; $display("FAIL link_up: got %b st=%0d exp 00011110/7", outs(), state); end
   endtask

   task automatic test_reset();
      hold_reset();
      checks++; if (outs() !== 8'b1110_0000) begin errors++; $display("FAIL reset_outs: got %b exp 11100000", outs()); end
      checks++; if (state !== 4'd0 || retry !== 3'd0) begin errors++; $display("FAIL reset_state: got st=%0d retry=%0d exp 0/0", state, retry); end
      release_reset();
   endtask

   task automatic test_bring_up();
      bring_up(0, 250);
      checks++; if (retry !== 3'd0) begin errors++; $display("FAIL bring_up_retry: got %0d exp 0", retry); end
   endtask

   task automatic test_lock_loss();
      int l;
      l = cyc;
      pll_lock = 1'b0;
      run_to(l + 2);
      checks++; if (link_up !== 1'b1) begin errors++; $display("FAIL lock_loss_early: got %b exp 1", link_up); end
      run_to(l + 3);
      checks++; if (outs() !== 8'b1110_0000 || state !== 4'd0) begin errors++; $display("FAIL lock_loss_drop: got %b st=%0d exp 11100000/0", outs(), state); end
      txdone = 1'b0;
      rxdone = 1'b0;
      bring_up(l + 3, l + 10);
      checks++; if (retry !== 3'd0) begin errors++; $display("FAIL lock_loss_retry: got %0d exp 0", retry); end
   endtask

   task automatic test_rxdone_loss();
      int d;
      d          = cyc;
      saw_pll_tx = 1'b0;
      rxdone     = 1'b0;
      run_to(d + 2);
      checks++; if (link_up !== 1'b1) begin errors++; $display("FAIL rxloss_early: got %b exp 1", link_up); end
      run_to(d + 3);
      checks++; if (outs() !== 8'b0011_0000 || state !== 4'd4) begin errors++; $display("FAIL rxloss_rx_rst: got %b st=%0d exp 00110000/4", outs(), state); end
      run_to(d + 6);
      checks++; if (rxreset !== 1'b1) begin errors++; $display("FAIL rxloss_pulse_hold: got %b exp 1", rxreset); end
      run_to(d + 7);
      checks++; if (rxreset !== 1'b0 || state !== 4'd5) begin errors++; $display("FAIL rxloss_pulse_end: got rx=%b st=%0d exp 0/5", rxreset, state); end
      run_to(d + 10);
      rxdone = 1'b1;
      run_to(d + 1036);
      checks++; if (link_up !== 1'b0) begin errors++; $display("FAIL rxloss_link_early: got %b exp 0", link_up); end
      run_to(d + 1037);
      checks++; if (link_up !== 1'b1 || retry !== 3'd0) begin errors++; $display("FAIL rxloss_relink: got link=%b retry=%0d exp 1/0", link_up, retry); end
      checks++; if (saw_pll_tx !== 1'b0) begin errors++; $display("FAIL rxloss_pll_tx_quiet: got %b exp 0", saw_pll_tx); end
   endtask

   task automatic test_monitor();
      int m;
      m = cyc;
      for (int k = 0; k < 16; k++) begin
         run_to(m + 2 * k);
         rx_err = 1'b1;
         tick();
         rx_err = 1'b0;
      end
`ifdef OCC_GTP_LINK_MONITOR_EN
      checks++; if (link_up !== 1'b0 || state !== 4'd4 || retry !== 3'd1) begin errors++; $display("FAIL mon16_trip: got link=%b st=%0d retry=%0d exp 0/4/1", link_up, state, retry); end
      run_to(m + 1060);
      checks++; if (link_up !== 1'b1) begin errors++; $display("FAIL mon16_relink: got %b exp 1", link_up); end
      m = cyc;
      for (int k = 0; k < 15; k++) begin
         run_to(m + 2 * k);
         rx_err = 1'b1;
         tick();
         rx_err = 1'b0;
      end
      run_to(m + 200);
      checks++; if (link_up !== 1'b1 || retry !== 3'd1) begin errors++; $display("FAIL mon15_hold: got link=%b retry=%0d exp 1/1", link_up, retry); end
`else
      run_to(m + 200);
      checks++; if (link_up !== 1'b1 || state !== 4'd7 || retry !== 3'd0) begin errors++; $display("FAIL mon_off_hold: got link=%b st=%0d retry=%0d exp 1/7/0", link_up, state, retry); end
`endif
   endtask

   task automatic test_min_latency();
      pll_lock = 1'b1;
      txdone   = 1'b1;
      rxdone   = 1'b1;
      hold_reset();
      release_reset();
      run_to(199);
      checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL min_pll_hold: got %b exp 1", pll_rst); end
      run_to(200);
      checks++; if (pll_rst !== 1'b0) begin errors++; $display("FAIL min_pll_fall: got %b exp 0", pll_rst); end
      run_to(1234);
      checks++; if (link_up !== 1'b0) begin errors++; $display("FAIL min_link_early: got %b exp 0", link_up); end
      run_to(1235);
      checks++; if (link_up !== 1'b1 || retry !== 3'd0) begin errors++; $display("FAIL min_link: got link=%b retry=%0d exp 1/0", link_up, retry); end
   endtask

   task automatic test_init_rst_mid();
      pll_lock = 1'b1;
      txdone   = 1'b1;
      rxdone   = 1'b0;
      hold_reset();
      release_reset();
      run_to(215);
      checks++; if (state !== 4'd5 || outs() !== 8'b0001_1000) begin errors++; $display("FAIL mid_wait_rxdone: got st=%0d %b exp 5/00011000", state, outs()); end
      init_rst = 1'b1;
      tick();
      checks++; if (outs() !== 8'b1110_0000 || state !== 4'd0) begin errors++; $display("FAIL mid_reset: got %b st=%0d exp 11100000/0", outs(), state); end
   endtask

   task automatic test_timeout_fault();
      int r;
      logic [3:0] exp_state;
      pll_lock = 1'b0;
      txdone   = 1'b0;
      rxdone   = 1'b0;
      hold_reset();
      release_reset();
      for (int n = 1; n <= 7; n++) begin
         run_to(800 * n - 1);
         checks++; if (retry !== 3'(n - 1)) begin errors++; $display("FAIL timeout_pre_%0d: got %0d exp %0d", n, retry, n - 1); end
         run_to(800 * n);
         exp_state = (n < 7) ? 4'd0 : 4'd8;
         checks++; if (retry !== 3'(n) || state !== exp_state) begin errors++; $display("FAIL timeout_%0d: got retry=%0d st=%0d exp %0d/%0d", n, retry, state, n, exp_state); end
      end
      checks++; if (outs() !== 8'b1110_0001) begin errors++; $display("FAIL fault_outs: got %b exp 11100001", outs()); end
      run_to(5650);
      checks++; if (state !== 4'd8 || fault !== 1'b1) begin errors++; $display("FAIL fault_stays: got st=%0d fault=%b exp 8/1", state, fault); end
      restart = 1'b1;
      tick();
      restart = 1'b0;
      r = cyc;
      checks++; if (state !== 4'd0 || retry !== 3'd0 || outs() !== 8'b1110_0000) begin errors++; $display("FAIL restart: got st=%0d retry=%0d %b exp 0/0/11100000", state, retry, outs()); end
      run_to(r + 200);
      checks++; if (state !== 4'd1 || pll_rst !== 1'b0) begin errors++; $display("FAIL restart_seq: got st=%0d pll=%b exp 1/0", state, pll_rst); end
   endtask

   initial begin
      init_rst   = 1'b1;
      restart    = 1'b0;
      pll_lock   = 1'b0;
      txdone     = 1'b0;
      rxdone     = 1'b0;
      rx_err     = 1'b0;
      cyc        = 0;
      checks     = 0;
      errors     = 0;
      saw_pll_tx = 1'b0;
      test_reset();
      test_bring_up();
      test_lock_loss();
      test_rxdone_loss();
      test_monitor();
      test_min_latency();
      test_init_rst_mid();
      test_timeout_fault();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
